// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- memory built-in self-test controller with 2-cycle read compare pipeline
module mbist_march_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CAPACITY   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  mem_write_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [2:0]            fail_element
);
    typedef enum logic [2:0] {IDLE, PRE, RUN, DRAIN, DONE} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(CAPACITY - 1);

    state_t                state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  op_q, op_d;
    logic                  drain_q, drain_d;
    logic                  fail_q, fail_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
    logic [2:0]            fail_elem_q, fail_elem_d;
    logic                  p1_v_q, p1_exp_q, p2_v_q, p2_exp_q;
    logic [ADDR_WIDTH-1:0] p1_addr_q, p2_addr_q;
    logic [2:0]            p1_elem_q, p2_elem_q;
    logic                  wr, last_op, down, last_addr, mismatch, wbg;
    logic [DATA_WIDTH-1:0] p2_word;

    assign wr        = (elem_q == 3'd0) || (op_q && elem_q != 3'd5);
    assign last_op   = (elem_q == 3'd0) || (elem_q == 3'd5) || op_q;
    assign down      = (elem_q == 3'd3) || (elem_q == 3'd4);
    assign last_addr = down ? (addr_q == '0) : (addr_q == LAST);
    assign p2_word   = {DATA_WIDTH{p2_exp_q}};
    assign mismatch  = p2_v_q && !fail_q && (mem_rdata != p2_word);
    // write data leads the write by a cycle, so it follows the element of the next operation
    assign wbg       = (state_q == PRE || state_q == RUN) && (elem_d == 3'd1 || elem_d == 3'd3);

    assign mem_write_read = (state_q == RUN) && wr;
    assign mem_address    = addr_q;
    assign mem_wdata      = {DATA_WIDTH{wbg}};
    assign busy           = state_q inside {PRE, RUN, DRAIN};
    assign done           = state_q == DONE;
    assign fail           = fail_q;
    assign fail_addr      = fail_addr_q;
    assign fail_data      = fail_data_q;
    assign fail_element   = fail_elem_q;

    // sequencing of states, march position and first-mismatch capture
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        op_d        = op_q;
        drain_d     = drain_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        fail_elem_d = fail_elem_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = PRE;
                    elem_d      = '0;
                    addr_d      = '0;
                    op_d        = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                    fail_elem_d = '0;
                end
            end
            PRE: state_d = RUN;
            RUN: begin
                drain_d = 1'b0;
                if (!last_op) begin
                    op_d = 1'b1;
                end else begin
                    op_d = 1'b0;
                    if (!last_addr) begin
                        addr_d = down ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
                    end else begin
                        elem_d  = (elem_q == 3'd5) ? 3'd0 : elem_q + 3'd1;
                        addr_d  = (elem_q == 3'd2 || elem_q == 3'd3) ? LAST : '0;
                        state_d = (elem_q == 3'd5) ? DRAIN : RUN;
                    end
                end
            end
            DRAIN: begin
                drain_d = 1'b1;
                state_d = drain_q ? DONE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
        if (mismatch) begin
            fail_d      = 1'b1;
            fail_addr_d = p2_addr_q;
            fail_data_d = mem_rdata ^ p2_word;
            fail_elem_d = p2_elem_q;
            if (state_q == RUN) begin
                state_d = DRAIN;
                drain_d = 1'b0;
            end
        end
    end

    // state registers and the 2-deep read compare pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            elem_q      <= '0;
            addr_q      <= '0;
            op_q        <= 1'b0;
            drain_q     <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_elem_q <= '0;
            p1_v_q      <= 1'b0;
            p1_exp_q    <= 1'b0;
            p1_addr_q   <= '0;
            p1_elem_q   <= '0;
            p2_v_q      <= 1'b0;
            p2_exp_q    <= 1'b0;
            p2_addr_q   <= '0;
            p2_elem_q   <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            drain_q     <= drain_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            fail_elem_q <= fail_elem_d;
            p1_v_q      <= (state_q == RUN) && !wr;
            p1_exp_q    <= (elem_q == 3'd2) || (elem_q == 3'd4);
            p1_addr_q   <= addr_q;
            p1_elem_q   <= elem_q;
            p2_v_q      <= p1_v_q;
            p2_exp_q    <= p1_exp_q;
            p2_addr_q   <= p1_addr_q;
            p2_elem_q   <= p1_elem_q;
        end
    end
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl: checks the March C- controller against an operation-list model and a latency-2 memory
module tb_mbist_march_ctrl;
    logic       clk = 1'b0;
    logic       rst, start;
    logic       mem_write_read, busy, done, fail;
    logic [3:0] mem_address, fail_addr;
    logic [7:0] mem_wdata, mem_rdata, fail_data;
    logic [2:0] fail_element;

    mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CAPACITY(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_write_read(mem_write_read), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .done(done), .fail(fail),
        .fail_addr(fail_addr), .fail_data(fail_data), .fail_element(fail_element)
    );

    always #5 clk = ~clk;

    int  tests = 0, fails = 0;
    int  c, run_ops, fi, bcnt;
    bit  active = 0, finished = 0, fault_en = 0;
    bit         exp_wr[160];
    logic [3:0] exp_addr[160];
    logic [7:0] exp_data[160];
    logic [3:0] efa;
    logic [7:0] efd;
    logic [2:0] efe;

    int nops[6]    = '{1, 2, 2, 2, 2, 1};
    bit dir[6]     = '{0, 0, 0, 1, 1, 0};
    bit opw[6][2]  = '{'{1, 0}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 0}};
    bit opb[6][2]  = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};

    // memory: wdata registered one cycle before the write, reads return after two edges
    logic [7:0] mem[16];
    logic [7:0] wd_q, r1;
    always @(posedge clk) begin
        wd_q <= mem_wdata;
        if (mem_write_read) begin
            mem[mem_address] <= wd_q;
            if (fault_en && mem_address == 4'd4 && !mem[4][4] && wd_q[4]) mem[5][4] <= 1'b1;
        end
        r1        <= mem[mem_address];
        mem_rdata <= r1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_fail"}, fail, 0);
        chk({nm, "_wr"}, mem_write_read, 0);
        chk({nm, "_addr"}, mem_address, 0);
        chk({nm, "_wdata"}, mem_wdata, 0);
        chk({nm, "_faddr"}, fail_addr, 0);
        chk({nm, "_fdata"}, fail_data, 0);
        chk({nm, "_felem"}, fail_element, 0);
    endtask

    // expand March C- into an ordered operation list and run it on an abstract memory
    task automatic build(input bit flt);
        logic [7:0] am[16];
        logic [7:0] d;
        int n = 0;
        int a;
        fi = -1; efa = 0; efd = 0; efe = 0;
        for (int e = 0; e < 6; e++)
            for (int i = 0; i < 16; i++) begin
                a = dir[e] ? 15 - i : i;
                for (int o = 0; o < nops[e]; o++) begin
                    d = opb[e][o] ? 8'hFF : 8'h00;
                    exp_wr[n] = opw[e][o];
                    exp_addr[n] = 4'(a);
                    exp_data[n] = d;
                    if (opw[e][o]) begin
                        if (flt && a == 4 && !am[4][4] && d[4]) am[5][4] = 1'b1;
                        am[a] = d;
                    end else if (fi < 0 && am[a] !== d) begin
                        fi = n; efa = 4'(a); efe = 3'(e); efd = am[a] ^ d;
                    end
                    n++;
                end
            end
        run_ops = (fi < 0) ? 160 : ((fi + 3 < 160) ? fi + 3 : 160);
    endtask

    always @(negedge clk) if (busy) bcnt++;

    // cycle-by-cycle comparison against the model; c=0 is the PRE cycle
    always @(negedge clk) begin
        if (active) begin
            c++;
            if (c >= 0) begin
                chk("busy", busy, c <= run_ops + 2);
                chk("done", done, c >= run_ops + 3);
                chk("wr", mem_write_read, (c >= 1 && c <= run_ops) ? exp_wr[c-1] : 1'b0);
                if (c >= 1 && c <= run_ops) chk("addr", mem_address, exp_addr[c-1]);
                if (c < run_ops && exp_wr[c]) chk("wdata_lead", mem_wdata, exp_data[c]);
                if (c == 0) begin
                    chk("pre_fail", fail, 0);
                    chk("pre_faddr", fail_addr, 0);
                    chk("pre_fdata", fail_data, 0);
                    chk("pre_felem", fail_element, 0);
                end
                if (c == run_ops + 3) begin
                    chk("end_fail", fail, fi >= 0);
                    if (fi >= 0) begin
                        chk("end_faddr", fail_addr, efa);
                        chk("end_fdata", fail_data, efd);
                        chk("end_felem", fail_element, efe);
                    end
                    active = 0;
                    finished = 1;
                end
            end
        end
    end

    task automatic launch(input bit flt);
        build(flt);
        fault_en = flt;
        @(posedge clk); #1;
        bcnt = 0; c = -2; finished = 0; active = 1; start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic run(input bit flt, input int pulse_at);
        launch(flt);
        if (pulse_at > 0) begin
            repeat (pulse_at) @(posedge clk);
            #1 start = 1;
            @(posedge clk); #1 start = 0;
        end
        for (int k = 0; k < 400 && !finished; k++) @(posedge clk);
        if (!finished) begin
            tests++; fails++;
            $display("FAIL timeout: done not reached, c=%0d", c);
            active = 0;
        end
    endtask

    initial begin
        rst = 1; start = 0;
        repeat (3) @(posedge clk);
        #1 chk_idle("reset");
        start = 1;
        @(posedge clk); #1 chk("rst_prio_busy", busy, 0);
        rst = 0; start = 0;

        run(0, 0);
        chk("clean_busy_cycles", bcnt, 163);
        chk("clean_fail", fail, 0);
        chk("pin_e3_first_addr", exp_addr[80], 15);
        chk("pin_e3_last_addr", exp_addr[111], 0);
        chk("pin_nofail", fi, -1);

        run(1, 0);
        chk("fault_busy_cycles", bcnt, 32);
        chk("fault_fail", fail, 1);
        chk("fault_addr", fail_addr, 5);
        chk("fault_elem", fail_element, 1);
        chk("fault_data", fail_data, 8'h10);
        chk("pin_fault_op", fi, 26);

        run(0, 0);
        chk("rerun_busy_cycles", bcnt, 163);
        chk("rerun_fail", fail, 0);

        run(0, 50);
        chk("busy_start_cycles", bcnt, 163);
        chk("busy_start_done", done, 1);

        launch(0);
        repeat (60) @(posedge clk);
        #1 active = 0; rst = 1;
        @(posedge clk); #1 rst = 0;
        chk_idle("mid_rst");
        @(posedge clk); #1 chk("mid_rst_stays_idle", busy, 0);

        run(0, 0);
        chk("after_rst_cycles", bcnt, 163);
        chk("after_rst_fail", fail, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mbist_march_ctrl.md
MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: memory address width.
REQ-003 SHALL have parameter CAPACITY, default 16: number of words tested, addresses 0..CAPACITY-1.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: one-cycle test request, honoured only in IDLE or DONE.
REQ-007 SHALL have port mem_write_read, output, 1: 1 = write, 0 = read, to memory write_read.
REQ-008 SHALL have port mem_address, output, ADDR_WIDTH: to memory address.
REQ-009 SHALL have port mem_wdata, output, DATA_WIDTH: to memory wdata.
REQ-010 SHALL have port mem_rdata, input, DATA_WIDTH: from memory rdata.
REQ-011 SHALL have port busy, output, 1: test in progress.
REQ-012 SHALL have port done, output, 1: test finished, level, held until next start or rst.
REQ-013 SHALL have port fail, output, 1: mismatch detected, valid while done=1.
REQ-014 SHALL have port fail_addr, output, ADDR_WIDTH: address of first mismatch.
REQ-015 SHALL have port fail_data, output, DATA_WIDTH: read data XOR expected at first mismatch.
REQ-016 SHALL have port fail_element, output, 3: March element index (0-5) of first mismatch.

Function
REQ-017 SHALL run March C- with background 0 = all-zeros and 1 = all-ones words: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0).
REQ-018 SHALL use states IDLE, PRE, RUN, DRAIN, DONE.
- IDLE/DONE + start -> PRE.
- PRE -> RUN after 1 cycle.
- RUN -> DRAIN after the last E5 read.
- DRAIN -> DONE after 2 cycles.
REQ-019 SHALL issue exactly one memory operation per RUN cycle, with no idle cycles between operations or elements; a fault-free run lasts 10*CAPACITY RUN cycles.
REQ-020 SHALL drive mem_wdata one cycle ahead of the matching mem_address/mem_write_read=1 cycle, because the memory registers wdata internally; the PRE cycle presents the first E0 write data.
REQ-021 SHALL read-compare mem_rdata against the expected background two cycles after the read is issued, since memory read latency is 2; expected value, address and element SHALL be carried in a 2-deep valid pipeline.
REQ-022 SHALL walk addresses in up elements from 0 to CAPACITY-1 and in down elements from CAPACITY-1 to 0; the address SHALL wrap to the element start value at element change, with no out-of-range address ever driven.
REQ-023 SHALL, on the first mismatch, latch fail_addr, fail_data and fail_element, set fail, stop issuing operations (mem_write_read=0), and enter DRAIN; later compares in the pipeline SHALL be ignored.
REQ-024 SHALL hold busy=1 in PRE, RUN and DRAIN, and 0 otherwise; done SHALL be 1 only in DONE.
REQ-025 SHALL drive mem_write_read=0 in IDLE, PRE, DRAIN and DONE.
REQ-026 SHALL, on start in DONE, clear done, fail and the fail_* outputs in the same cycle it enters PRE.
REQ-027 SHALL ignore start while busy=1.

Reset
REQ-028 SHALL, with rst=1 at a clock edge, force IDLE and drive busy, done, fail, mem_write_read, mem_address, mem_wdata and fail_* to 0, and flush the compare pipeline, including mid-test.
REQ-029 SHALL give rst priority over start in the same cycle.

Verification
REQ-030 SHALL pass this case: fault-free memory, CAPACITY=16 -> start; busy for 1+160+2 cycles; done=1; fail=0.
REQ-031 SHALL pass this case: memory with bit-4 rising-edge coupling fault (write with bit 4 rising at address 4 sets bit 4 of address 5), DATA_WIDTH=8 -> done=1, fail=1, fail_addr=5, fail_element=1, fail_data=8'h10.
REQ-032 SHALL pass this case: a write/read trace check -> every write's data appears on mem_wdata exactly one cycle before its address; E3 addresses run 15 down to 0.
REQ-033 SHALL pass this case: rst asserted in E2 -> next cycle all outputs are 0 and state is IDLE; a later start runs a full test with fail=0.
REQ-034 SHALL pass this case: start pulsed while busy -> no effect; run length stays 163 cycles.
REQ-035 SHALL pass this case: start in DONE after a failing run -> fail and fail_* clear on entry to PRE, and a fault-free rerun ends with fail=0.
